// File: rtl/requant_shift_pipe_pkg.sv
// Shared widths, clamp limits and the stage-2 payload type for the requantiser pipeline.
// The 17-bit accumulator width leaves headroom for the rounding bias.
package requant_shift_pipe_pkg;
    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int SH_W  = 4;
    localparam int CNT_W = 16;
    localparam int ACC_W = IN_W + 1;

    localparam int OUT_MAX = 127;
    localparam int OUT_MIN = -128;

    typedef struct packed {
        logic signed [OUT_W-1:0] data;
        logic                    sat;
    } stage_t;
endpackage

// File: rtl/requant_round_sat.sv
// Combinational arithmetic for both pipe stages: round/shift of a raw word,
// and clamping of an already shifted value into the signed output range.
module requant_round_sat
    import requant_shift_pipe_pkg::*;
(
    input  logic signed [IN_W-1:0]  i_data,
    input  logic [SH_W-1:0]         i_shift,
    input  logic                    i_round_en,
    output logic signed [ACC_W-1:0] o_shifted,
    input  logic signed [ACC_W-1:0] i_s1,
    output stage_t                  o_payload
);
    localparam logic signed [ACC_W-1:0] W_HI = ACC_W'(OUT_MAX);
    localparam logic signed [ACC_W-1:0] W_LO = ACC_W'(OUT_MIN);

    logic [ACC_W-1:0]        w_bias;
    logic signed [ACC_W-1:0] w_sum;

    always_comb begin
        w_bias = '0;
        if (i_round_en && (i_shift != '0)) begin
            w_bias = ACC_W'(1) << (i_shift - SH_W'(1));
        end
        // Sign-extend one bit so the half-up bias can never overflow.
        w_sum     = {i_data[IN_W-1], i_data} + w_bias;
        o_shifted = w_sum >>> i_shift;
    end

    always_comb begin
        o_payload.data = i_s1[OUT_W-1:0];
        o_payload.sat  = 1'b0;
        if (i_s1 > W_HI) begin
            o_payload.data = OUT_W'(OUT_MAX);
            o_payload.sat  = 1'b1;
        end else if (i_s1 < W_LO) begin
            o_payload.data = OUT_W'(OUT_MIN);
            o_payload.sat  = 1'b1;
        end
    end
endmodule

// File: rtl/requant_shift_pipe.sv
// Two-stage valid/ready requantiser: shift/round in stage 1, saturate in stage 2,
// plus a sticky counter of clipped words delivered downstream.
module requant_shift_pipe
    import requant_shift_pipe_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [IN_W-1:0]         i_in_data,
    input  logic [SH_W-1:0]         i_in_shift,
    input  logic                    i_round_en,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [OUT_W-1:0]        o_out_data,
    output logic                    o_out_sat,
    input  logic                    i_sat_clr,
    output logic [CNT_W-1:0]        o_sat_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                    r_s1_valid;
    logic signed [ACC_W-1:0] r_s1_data;
    logic                    r_s2_valid;
    stage_t                  r_s2;
    logic [CNT_W-1:0]        r_sat_count;

    logic                    w_s1_en;
    logic                    w_s2_en;
    logic                    w_out_fire;
    logic signed [ACC_W-1:0] w_shifted;
    stage_t                  w_payload;

    requant_round_sat u_round_sat (
        .i_data     ($signed(i_in_data)),
        .i_shift    (i_in_shift),
        .i_round_en (i_round_en),
        .o_shifted  (w_shifted),
        .i_s1       (r_s1_data),
        .o_payload  (w_payload)
    );

    // Ready ripples back combinationally from the output so a full pipe still streams.
    assign w_s2_en    = !r_s2_valid || i_out_ready;
    assign w_s1_en    = !r_s1_valid || w_s2_en;
    assign w_out_fire = r_s2_valid && i_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_data <= w_shifted;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2 <= w_payload;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (i_sat_clr) begin
            r_sat_count <= '0;
        end else if (w_out_fire && r_s2.sat && (r_sat_count != CNT_MAX)) begin
            r_sat_count <= r_sat_count + CNT_W'(1);
        end
    end

    assign o_in_ready  = w_s1_en;
    assign o_out_valid = r_s2_valid;
    assign o_out_data  = r_s2.data;
    assign o_out_sat   = r_s2.sat;
    assign o_sat_count = r_sat_count;
endmodule

// File: tb/tb_requant_shift_pipe.sv
// Scoreboard bench for requant_shift_pipe: driver pushes model results, monitor pops on output transfers.
module tb_requant_shift_pipe;
    import requant_shift_pipe_pkg::*;

    typedef struct {
        int data;
        bit sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [IN_W-1:0]   i_in_data;
    logic [SH_W-1:0]   i_in_shift;
    logic              i_round_en;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [OUT_W-1:0]  o_out_data;
    logic              o_out_sat;
    logic              i_sat_clr;
    logic [CNT_W-1:0]  o_sat_count;

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    int   n_txn = 0;
    bit   quiet = 0;
    bit   prev_stall = 0;
    int   prev_data = 0;
    exp_t sb[$];

    requant_shift_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .i_in_shift  (i_in_shift),
        .i_round_en  (i_round_en),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_sat   (o_out_sat),
        .i_sat_clr   (i_sat_clr),
        .o_sat_count (o_sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact floor division by 2**sh after an optional half-up bias, then clamp.
    function automatic exp_t ref_model(int d, int sh, bit rnd);
        exp_t e;
        int   v;
        int   p;
        int   q;
        v = d;
        if (rnd && sh > 0) v = v + (1 << (sh - 1));
        p = 1 << sh;
        q = v / p;
        if ((v % p) != 0 && v < 0) q = q - 1;
        if (q > 127) begin
            e.data = 127;  e.sat = 1'b1;
        end else if (q < -128) begin
            e.data = -128; e.sat = 1'b1;
        end else begin
            e.data = q;    e.sat = 1'b0;
        end
        return e;
    endfunction

    task automatic send(logic [15:0] d, int sh, bit rnd);
        bit done;
        int dv;
        done = 0;
        dv = int'($signed(d));
        i_in_valid = 1'b1;
        i_in_data  = d;
        i_in_shift = sh[3:0];
        i_round_en = rnd;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (o_in_ready) begin
                sb.push_back(ref_model(dv, sh, rnd));
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        i_in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic idle(int n);
        i_in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every output transfer, stall stability and the counter model.
    always @(negedge clk) begin
        exp_t e;
        bit   popped_sat;
        if (rst) begin
            prev_stall = 0;
            exp_cnt    = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(o_out_valid), 1);
                check("stall_data", int'($signed(o_out_data)), prev_data);
            end
            check("sat_count", int'(o_sat_count), exp_cnt);
            popped_sat = 0;
            if (o_out_valid && i_out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", int'($signed(o_out_data)), e.data);
                    check("out_sat", int'(o_out_sat), int'(e.sat));
                    popped_sat = e.sat;
                    n_txn++;
                    if (!quiet)
                        $display("txn %0d: out_data=%0d out_sat=%0d sat_count=%0d",
                                 n_txn, $signed(o_out_data), o_out_sat, o_sat_count);
                end
            end
            prev_stall = o_out_valid && !i_out_ready;
            prev_data  = int'($signed(o_out_data));
            if (i_sat_clr) exp_cnt = 0;
            else if (popped_sat && exp_cnt < 65535) exp_cnt++;
        end
    end

    initial begin
        bit rdone;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_in_shift  = '0;
        i_round_en  = 1'b0;
        i_out_ready = 1'b1;
        i_sat_clr   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(o_out_valid), 0);
        check("rst_out_data", int'(o_out_data), 0);
        check("rst_out_sat", int'(o_out_sat), 0);
        check("rst_sat_count", int'(o_sat_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(o_in_ready), 1);
        @(posedge clk); #1;

        // Basic shift and two-cycle latency.
        send(16'h0100, 4, 0);
        @(negedge clk);
        check("lat_cycle1_valid", int'(o_out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_cycle2_valid", int'(o_out_valid), 1);
        check("lat_cycle2_data", int'(o_out_data), 16);
        @(posedge clk); #1;

        // Rounding versus truncation on both signs.
        send(16'd24, 4, 1);
        send(16'd24, 4, 0);
        send(-16'sd24, 4, 1);
        send(-16'sd24, 4, 0);
        idle(4);

        // Saturation boundaries.
        send(16'h7FFF, 0, 0);
        send(16'h8000, 0, 0);
        send(16'h8000, 15, 0);
        idle(5);
        check("sat_count_after_three", int'(o_sat_count), 2);

        // Backpressure: pipe fills after two accepts and holds.
        i_out_ready = 1'b0;
        send(16'd1, 0, 0);
        send(16'd2, 0, 0);
        fork
            begin
                send(16'd3, 0, 0);
                send(16'd4, 0, 0);
                send(16'd5, 0, 0);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in_ready", int'(o_in_ready), 0);
                    check("bp_out_data", int'(o_out_data), 1);
                end
                @(posedge clk); #1;
                i_out_ready = 1'b1;
            end
        join
        idle(8);
        check("bp_drained", sb.size(), 0);

        // Asynchronous reset with two saturated words in flight.
        i_out_ready = 1'b0;
        send(16'h7FFF, 0, 0);
        send(16'h8000, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(o_out_valid), 0);
        check("midrst_sat_count", int'(o_sat_count), 0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        i_out_ready = 1'b1;
        idle(6);
        check("midrst_no_ghost", int'(o_out_valid), 0);

        // Randomised traffic with random downstream stalls.
        rdone = 0;
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    send(16'($urandom), int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
                    if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
                end
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #1;
                    i_out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        i_out_ready = 1'b1;
        idle(10);
        check("rand_drained", sb.size(), 0);

        // Counter saturation at all-ones.
        quiet = 1;
        for (int n = 0; n < 65540; n++) send(16'h7FFF, 0, 0);
        idle(4);
        quiet = 0;
        check("cnt_stuck_max", int'(o_sat_count), 65535);

        // Clear wins over a same-cycle saturated transfer.
        send(16'h7FFF, 0, 0);
        @(posedge clk); #1;
        i_sat_clr = 1'b1;
        @(negedge clk);
        check("clr_out_valid", int'(o_out_valid), 1);
        check("clr_out_sat", int'(o_out_sat), 1);
        @(posedge clk); #1;
        i_sat_clr = 1'b0;
        @(negedge clk);
        check("clr_result", int'(o_sat_count), 0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
